// File: rtl/fp_decoder_if.sv
// ---------------------------------------------------------------------------
// fp_decoder_if
// Purpose : groups the request/result signals of the 9-bit float to 12-bit
//           two's-complement decoder.
// Signals : in_valid       - conversion request (sampled only while idle)
//           S_in/E_in/F_in - sign, 3-bit exponent, 5-bit significand
//           D_out          - 12-bit two's-complement result, held until next done
//           done           - one-cycle pulse marking D_out/ovf updated
//           busy           - conversion in progress
//           ovf            - result was saturated
// Modports: master drives the request side, slave is the decoder.
// ---------------------------------------------------------------------------
interface fp_decoder_if;
    logic        in_valid;
    logic        S_in;
    logic [2:0]  E_in;
    logic [4:0]  F_in;
    logic [11:0] D_out;
    logic        done;
    logic        busy;
    logic        ovf;

    modport master (
        output in_valid, S_in, E_in, F_in,
        input  D_out, done, busy, ovf
    );

    modport slave (
        input  in_valid, S_in, E_in, F_in,
        output D_out, done, busy, ovf
    );
endinterface

// File: rtl/fp_decoder.sv
// ---------------------------------------------------------------------------
// fp_decoder
// Purpose : sequential converter from the 9-bit float (S, E[2:0], F[4:0]) to
//           a 12-bit two's-complement value D = (-1)^S * F * 2^E. The
//           magnitude is shifted left once per clock under an exponent
//           counter, then sign-applied and saturated in a final cycle.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset
//           bus  - fp_decoder_if.slave (request inputs, result outputs)
// Latency : E+2 cycles from the accepting edge to done.
// ---------------------------------------------------------------------------
module fp_decoder (
    input  logic         clk,
    input  logic         rst,
    fp_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_sign;
    logic [2:0]  r_cnt;
    logic [11:0] r_mag;
    logic [11:0] r_d;
    logic        r_ovf;
    logic        r_done;
    logic [12:0] w_res;

    // Applies the sign to the unsigned magnitude and clamps to the 12-bit
    // two's-complement range. Returns {ovf, value}. A 13-bit signed
    // intermediate holds +/-3968 without wrap; -0 naturally yields 0.
    function automatic logic [12:0] saturate(input logic sign, input logic [11:0] mag);
        logic signed [12:0] val;
        if (sign)
            val = -$signed({1'b0, mag});
        else
            val = $signed({1'b0, mag});
        if (val > 13'sd2047)
            return {1'b1, 12'h7FF};
        else if (val < -13'sd2048)
            return {1'b1, 12'h800};
        else
            return {1'b0, val[11:0]};
    endfunction

    assign w_res = saturate(r_sign, r_mag);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = SHIFT;
            SHIFT:   if (r_cnt == 3'd0) w_next = FINAL;
            FINAL:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_cnt  <= 3'd0;
            r_mag  <= 12'd0;
            r_d    <= 12'd0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sign <= bus.S_in;
                        r_cnt  <= bus.E_in;
                        r_mag  <= {7'b0, bus.F_in};
                    end
                end
                SHIFT: begin
                    // Max 31 << 7 = 3968 fits 12 unsigned bits; nothing is lost.
                    if (r_cnt != 3'd0) begin
                        r_mag <= r_mag << 1;
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                FINAL: begin
                    r_ovf  <= w_res[12];
                    r_d    <= w_res[11:0];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.D_out = r_d;
    assign bus.ovf   = r_ovf;
    assign bus.done  = r_done;
    assign bus.busy  = (r_state != IDLE);

endmodule

// File: tb/tb_fp_decoder.sv
module tb_fp_decoder;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    fp_decoder_if bus ();

    fp_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done after an accept edge; lat = edges after accept.
    task automatic wait_done(output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end
        end
    endtask

    task automatic run(input logic s, input logic [2:0] e, input logic [4:0] f,
                       input logic [11:0] xd, input logic xo, input int xl, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.S_in = s;
        bus.E_in = e;
        bus.F_in = f;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({tag, " busy_after_accept"}, {31'd0, bus.busy}, 32'd1);
        wait_done(lat, seen);
        chk({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " latency"}, lat, xl);
        chk({tag, " D_out"}, {20'd0, bus.D_out}, {20'd0, xd});
        chk({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, xo});
        chk({tag, " busy_in_done"}, {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        chk({tag, " done_one_cycle"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " D_out_held"}, {20'd0, bus.D_out}, {20'd0, xd});
    endtask

    initial begin
        int lat;
        bit seen;
        int ndone;
        int v;
        logic [11:0] xd;
        logic xo;

        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.S_in = 1'b0;
        bus.E_in = 3'd0;
        bus.F_in = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset D_out", {20'd0, bus.D_out}, 32'h000);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset ovf", {31'd0, bus.ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic conversions, hand-computed
        run(1'b0, 3'd3, 5'b10110, 12'h0B0, 1'b0, 5, "pos176");
        run(1'b1, 3'd3, 5'b10110, 12'hF50, 1'b0, 5, "neg176");
        run(1'b0, 3'd0, 5'b00101, 12'h005, 1'b0, 2, "e0");
        run(1'b1, 3'd4, 5'b00000, 12'h000, 1'b0, 6, "negzero");
        run(1'b0, 3'd7, 5'b11111, 12'h7FF, 1'b1, 9, "satpos");
        run(1'b1, 3'd7, 5'b10000, 12'h800, 1'b0, 9, "neg2048");
        run(1'b1, 3'd7, 5'b11111, 12'h800, 1'b1, 9, "satneg");
        run(1'b0, 3'd6, 5'b11111, 12'h7C0, 1'b0, 8, "pos1984");

        // Abort mid-SHIFT with E=5 (D_out currently 7C0)
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.S_in = 1'b0;
        bus.E_in = 3'd5;
        bus.F_in = 5'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort busy_before_rst", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort D_out", {20'd0, bus.D_out}, 32'h000);
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        chk("abort ovf", {31'd0, bus.ovf}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        chk("abort no_done", ndone, 0);

        // in_valid held through a conversion, then back-to-back in done cycle
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.S_in = 1'b0;
        bus.E_in = 3'd2;
        bus.F_in = 5'd3;
        @(posedge clk); #1;
        bus.S_in = 1'b1;
        bus.E_in = 3'd7;
        bus.F_in = 5'd31;
        wait_done(lat, seen);
        chk("hold done_seen", {31'd0, seen}, 32'd1);
        chk("hold latency", lat, 4);
        chk("hold D_out", {20'd0, bus.D_out}, 32'h00C);
        chk("hold ovf", {31'd0, bus.ovf}, 32'd0);
        bus.S_in = 1'b0;
        bus.E_in = 3'd1;
        bus.F_in = 5'b00011;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("b2b busy", {31'd0, bus.busy}, 32'd1);
        wait_done(lat, seen);
        chk("b2b done_seen", {31'd0, seen}, 32'd1);
        chk("b2b latency", lat, 3);
        chk("b2b D_out", {20'd0, bus.D_out}, 32'h006);
        chk("b2b ovf", {31'd0, bus.ovf}, 32'd0);

        // Full sweep against an integer reference model
        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < 8; e++) begin
                for (int f = 0; f < 32; f++) begin
                    v = f * (1 << e);
                    if (s != 0) v = -v;
                    xo = 1'b0;
                    if (v > 2047) begin
                        v = 2047;
                        xo = 1'b1;
                    end else if (v < -2048) begin
                        v = -2048;
                        xo = 1'b1;
                    end
                    xd = v[11:0];
                    run(s[0], e[2:0], f[4:0], xd, xo, e + 2,
                        $sformatf("sweep s%0d e%0d f%0d", s, e, f));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_decoder.md
# fp_decoder

Sequential converter from the team's 9-bit floating-point format (sign S, 3-bit exponent E, 5-bit significand F) back to a 12-bit two's-complement value D = (−1)^S × F × 2^E. It is the inverse-direction companion of the two's-complement-to-float encoder/rounder path. The block sits on the output side of the converter project and regenerates integers for loop-back checking and display. Magnitude is built by one left shift per clock, driven by an exponent counter, then sign-applied and saturated.

## Interface
- No parameters. Widths are fixed: S 1, E 3, F 5, D 12.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request to convert; sampled only while busy=0.
- S_in  input  1  sign bit.
- E_in  input  3  exponent, 0–7.
- F_in  input  5  significand, unsigned integer 0–31.
- D_out  output  12  two's-complement result; holds its value until the next done.
- done  output  1  one-cycle pulse marking D_out and ovf as updated.
- busy  output  1  high while a conversion is in progress.
- ovf  output  1  result saturated; valid with done and held with D_out.

## Operation
- States: IDLE, SHIFT, FINAL.
- **IDLE**
  - busy=0.
  - On an edge with in_valid=1: capture sign←S_in, cnt←E_in, mag←{7'b0,F_in} (12-bit unsigned); go to SHIFT.
- **SHIFT**
  - busy=1.
  - Each edge with cnt≠0: mag←mag<<1, cnt←cnt−1.
  - Edge with cnt=0: go to FINAL.
  - SHIFT therefore lasts E+1 cycles.
  - mag never exceeds 31×128=3968, so 12 unsigned bits suffice and no bits are lost.
- **FINAL**
  - busy=1.
  - On the edge, load D_out, ovf and done=1, then return to IDLE.
  - Result rules:
    - sign=0, mag≤2047: D_out=mag, ovf=0.
    - sign=0, mag>2047: D_out=12'h7FF, ovf=1.
    - sign=1, mag≤2048: D_out=−mag (two's complement, 12 bits), ovf=0. mag=2048 gives 12'h800 exactly.
    - sign=1, mag>2048: D_out=12'h800, ovf=1.
    - sign=1, mag=0: D_out=12'h000 (no negative zero).
- done is high for exactly one cycle, the cycle after FINAL. busy is low in that same cycle.
- in_valid while busy=1 is ignored, not queued. The input buses need only be stable on the accepting edge.
- Back-to-back: in_valid=1 during the done cycle is accepted, because the block is in IDLE.

## Timing
- Reset (rst=1 at a rising edge) forces:
  - state=IDLE
  - D_out=12'h000
  - done=0, busy=0, ovf=0
  - cnt=0, mag=0
- rst has priority over every other action, including mid-SHIFT or in FINAL. An aborted conversion produces no done pulse.
- Accept edge = edge 0. busy=1 from after edge 0 until after edge E+2.
- done=1 and the new D_out/ovf appear after edge E+2, so latency is E+2 cycles.
  - Minimum latency: 2 cycles (E=0).
  - Maximum latency: 9 cycles (E=7).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then check idle outputs: D_out=000, done=0, busy=0, ovf=0. Pulse rst again mid-SHIFT with E=5 → outputs return to reset values next cycle; no done pulse follows.
- S=0, E=3, F=10110 → D_out=12'h0B0 (176), ovf=0, done exactly 5 cycles after accept. Repeat with S=1 → 12'hF50 (−176).
- E=0, F=00101, S=0 → D_out=12'h005, done 2 cycles after accept. Then S=1, F=0, E=4 → D_out=12'h000, ovf=0.
- Saturation:
  - S=0, E=7, F=11111 → 12'h7FF, ovf=1, latency 9.
  - S=1, E=7, F=10000 → 12'h800, ovf=0.
  - S=1, E=7, F=11111 → 12'h800, ovf=1.
- Hold in_valid=1 with new operands throughout a conversion → only the first is converted. Assert in_valid=1 in the done cycle with E=1, F=00011 → accepted, D_out=12'h006 three cycles later.
- Sweep all S/E/F (512 cases) against a reference model → every D_out, ovf and latency matches the rules above.
